axi_lite_clint: RTL and testbench

AXI_LITE_CLINT -- requirements
Module: axi_lite_clint

---
 rtl/liang_pkg.sv | 6 +
 rtl/axi_lite_clint.sv | 218 +++++++++++++++++++++
 tb/tb_axi_lite_clint.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/liang_pkg.sv
// Shared bus-width constants for the AXI-Lite peripherals of this platform.
package liang_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int STRB_WIDTH = 4;
endpackage

// File: rtl/axi_lite_clint.sv
// AXI4-Lite core-local interruptor: 64-bit mtime/mtimecmp timer and msip software
// interrupt bit, with independent read and write channel state machines.
module axi_lite_clint
  import liang_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned           TICK_DIV  = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] araddr_i,
  input  logic                  arvalid_i,
  output logic                  arready_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic                  rready_i,
  input  logic [ADDR_WIDTH-1:0] awaddr_i,
  input  logic                  awvalid_i,
  output logic                  awready_o,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [1:0]            bresp_o,
  output logic                  bvalid_o,
  input  logic                  bready_i,
  output logic                  timer_irq_o,
  output logic                  soft_irq_o
);

  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  localparam int unsigned        PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [1:0]         RESP_OKAY   = 2'b00;
  localparam logic [1:0]         RESP_SLVERR = 2'b10;

  function automatic logic is_mapped(input logic [ADDR_WIDTH-1:2] a);
    return (a[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]) && (a[4:2] <= 3'd4);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_v,
                                                        input logic [DATA_WIDTH-1:0] new_v,
                                                        input logic [STRB_WIDTH-1:0] strb);
    logic [DATA_WIDTH-1:0] r;
    r = old_v;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  r_state_e              r_state_q, r_state_d;
  w_state_e              w_state_q, w_state_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  msip_q, msip_d;
  logic                  timer_irq_q, timer_irq_d;

  logic [DATA_WIDTH-1:0] rd_word;
  logic                  commit, wr_en, tick;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  unused_addr_lsbs;

  assign unused_addr_lsbs = ^{araddr_i[1:0], wr_addr[1:0]};

  // Read mux looks at the pre-edge register values, so a same-cycle write or tick is not visible.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_word = '0;
    if (araddr_i[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5]) begin
      case (araddr_i[4:2])
        3'd0:    rd_word = mtime_q[31:0];
        3'd1:    rd_word = mtime_q[63:32];
        3'd2:    rd_word = mtimecmp_q[31:0];
        3'd3:    rd_word = mtimecmp_q[63:32];
        3'd4:    rd_word = {{(DATA_WIDTH-1){1'b0}}, msip_q};
        default: rd_word = '0;
      endcase
    end
  end

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    case (r_state_q)
      R_IDLE: if (arvalid_i) begin
        rdata_d   = rd_word;
        r_state_d = R_DATA;
      end
      R_DATA: if (rready_i) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // AW and W may arrive together or in either order; the write commits on the second handshake.
  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    commit    = 1'b0;
    wr_addr   = awaddr_q;
    wr_data   = wdata_q;
    wr_strb   = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        if (awvalid_i && wvalid_i) begin
          commit  = 1'b1;
          wr_addr = awaddr_i;
          wr_data = wdata_i;
          wr_strb = wstrb_i;
        end else if (awvalid_i) begin
          awaddr_d  = awaddr_i;
          w_state_d = W_DATA;
        end else if (wvalid_i) begin
          wdata_d   = wdata_i;
          wstrb_d   = wstrb_i;
          w_state_d = W_ADDR;
        end
      end
      W_ADDR: if (awvalid_i) begin
        commit  = 1'b1;
        wr_addr = awaddr_i;
      end
      W_DATA: if (wvalid_i) begin
        commit  = 1'b1;
        wr_data = wdata_i;
        wr_strb = wstrb_i;
      end
      W_RESP: if (bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    if (commit) begin
      w_state_d = W_RESP;
      bresp_d   = is_mapped(wr_addr[ADDR_WIDTH-1:2]) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  // A write to either mtime half wins over the tick and restarts the prescaler.
  always_comb begin
    wr_en       = commit && is_mapped(wr_addr[ADDR_WIDTH-1:2]) && (wr_strb != '0);
    tick        = (presc_q == PRESC_MAX);
    presc_d     = tick ? '0 : presc_q + PRESC_W'(1);
    mtime_d     = mtime_q + 64'(tick);
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    if (wr_en) begin
      case (wr_addr[4:2])
        3'd0: begin
          mtime_d = {mtime_q[63:32], merge_bytes(mtime_q[31:0], wr_data, wr_strb)};
          presc_d = '0;
        end
        3'd1: begin
          mtime_d = {merge_bytes(mtime_q[63:32], wr_data, wr_strb), mtime_q[31:0]};
          presc_d = '0;
        end
        3'd2:    mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], wr_data, wr_strb);
        3'd3:    mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], wr_data, wr_strb);
        3'd4:    msip_d = wr_strb[0] ? wr_data[0] : msip_q;
        default: ;
      endcase
    end
    timer_irq_d = (mtime_d >= mtimecmp_d);
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state_q   <= R_IDLE;
      w_state_q   <= W_IDLE;
      rdata_q     <= '0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      bresp_q     <= RESP_OKAY;
      presc_q     <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      timer_irq_q <= 1'b0;
    end else begin
      r_state_q   <= r_state_d;
      w_state_q   <= w_state_d;
      rdata_q     <= rdata_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      bresp_q     <= bresp_d;
      presc_q     <= presc_d;
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign arready_o   = (r_state_q == R_IDLE);
  assign rvalid_o    = (r_state_q == R_DATA);
  assign rdata_o     = rdata_q;
  assign awready_o   = (w_state_q == W_IDLE) || (w_state_q == W_ADDR);
  assign wready_o    = (w_state_q == W_IDLE) || (w_state_q == W_DATA);
  assign bvalid_o    = (w_state_q == W_RESP);
  assign bresp_o     = bresp_q;
  assign timer_irq_o = timer_irq_q;
  assign soft_irq_o  = msip_q;

endmodule

// File: tb/tb_axi_lite_clint.sv
// Randomised bench for axi_lite_clint: a transaction-level model predicts read data,
// write responses and interrupt levels; a monitor checks them as the DUT presents them.
module tb_axi_lite_clint;

  localparam logic [31:0] BASE = 32'h0200_0000;
  localparam int          TD   = 1;

  logic        clk, rst_n;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        timer_irq, soft_irq;

  axi_lite_clint #(.BASE_ADDR(BASE), .TICK_DIV(TD)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rvalid_o(rvalid), .rready_i(rready),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .timer_irq_o(timer_irq), .soft_irq_o(soft_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct { logic [31:0] data; int at; } rexp_t;
  typedef struct { logic [1:0]  resp; int at; } bexp_t;
  rexp_t rq[$];
  bexp_t bq[$];

  int          edge_n;
  logic [63:0] mt_base;   // mtime value loaded at edge mt_edge
  int          mt_edge;
  logic [63:0] cmp_m;
  logic        msip_m;
  logic        have_a, have_d;
  logic [31:0] pend_a, pend_d;
  logic [3:0]  pend_s;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  function automatic logic [63:0] mtime_at(input int n);
    return mt_base + 64'((n - mt_edge) / TD);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (o & ~m) | (d & m);
  endfunction

  function automatic logic in_window(input logic [31:0] a);
    return (a & 32'hFFFF_FFE0) == BASE;
  endfunction

  function automatic logic [31:0] reg_read(input logic [31:0] a, input int n);
    logic [63:0] t;
    logic [31:0] off;
    t   = mtime_at(n);
    off = a & 32'h0000_001C;
    if (!in_window(a)) return 32'h0;
    if (off == 32'h00) return t[31:0];
    if (off == 32'h04) return t[63:32];
    if (off == 32'h08) return cmp_m[31:0];
    if (off == 32'h0C) return cmp_m[63:32];
    if (off == 32'h10) return {31'h0, msip_m};
    return 32'h0;
  endfunction

  // At each falling edge: check levels after edge n, then predict what edge n+1 will do.
  always @(negedge clk) begin : model
    logic [31:0] a, d, off;
    logic [3:0]  s;
    logic        ha, hd;
    logic [63:0] cur;
    logic [31:0] mv;
    int          n;
    if (!rst_n) begin
      mt_base <= '0;
      mt_edge <= 0;
      cmp_m   <= '1;
      msip_m  <= 1'b0;
      have_a  <= 1'b0;
      have_d  <= 1'b0;
      rq.delete();
      bq.delete();
    end else begin
      n = edge_n;
      check("timer_irq", timer_irq, mtime_at(n) >= cmp_m);
      check("soft_irq", soft_irq, msip_m);
      if (arvalid && arready) rq.push_back('{data: reg_read(araddr, n), at: n + 1});
      ha = have_a; hd = have_d; a = pend_a; d = pend_d; s = pend_s;
      if (awvalid && awready) begin ha = 1'b1; a = awaddr; end
      if (wvalid && wready) begin hd = 1'b1; d = wdata; s = wstrb; end
      if (ha && hd) begin
        have_a <= 1'b0;
        have_d <= 1'b0;
        off = a & 32'h0000_001C;
        if (!in_window(a) || off > 32'h10) begin
          bq.push_back('{resp: 2'b10, at: n + 1});
        end else begin
          bq.push_back('{resp: 2'b00, at: n + 1});
          cur = mtime_at(n);
          if (off == 32'h00) begin
            cur[31:0] = byte_merge(cur[31:0], d, s);
            if (s != 4'h0) begin mt_base <= cur; mt_edge <= n + 1; end
          end else if (off == 32'h04) begin
            cur[63:32] = byte_merge(cur[63:32], d, s);
            if (s != 4'h0) begin mt_base <= cur; mt_edge <= n + 1; end
          end else if (off == 32'h08) begin
            cmp_m <= {cmp_m[63:32], byte_merge(cmp_m[31:0], d, s)};
          end else if (off == 32'h0C) begin
            cmp_m <= {byte_merge(cmp_m[63:32], d, s), cmp_m[31:0]};
          end else begin
            mv = byte_merge({31'h0, msip_m}, d, s);
            msip_m <= mv[0];
          end
        end
      end else begin
        have_a <= ha; have_d <= hd;
        pend_a <= a;  pend_d <= d; pend_s <= s;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic rv_prev, bv_prev;

  always @(negedge clk) begin : monitor
    if (!rst_n) begin
      rv_prev <= 1'b0;
      bv_prev <= 1'b0;
    end else begin
      check("arready_vs_rvalid", arready, !rvalid);
      check("awwready_vs_bvalid", awready || wready, !bvalid);
      if (rvalid) begin
        if (rq.size() == 0) note_fail("rvalid_without_request");
        else begin
          if (!rv_prev) check("r_latency_edge", edge_n, rq[0].at);
          check("rdata", rdata, rq[0].data);
          if (rready) void'(rq.pop_front());
        end
      end
      if (bvalid) begin
        if (bq.size() == 0) note_fail("bvalid_without_request");
        else begin
          if (!bv_prev) check("b_latency_edge", edge_n, bq[0].at);
          check("bresp", bresp, bq[0].resp);
          if (bready) void'(bq.pop_front());
        end
      end
      rv_prev <= rvalid;
      bv_prev <= bvalid;
    end
  end

  // ---------------- drivers (all start at posedge + 1) ----------------
  task automatic idle(input int c);
    repeat (c) begin @(posedge clk); #1; end
  endtask

  task automatic rd(input logic [31:0] a, input int rdly);
    int i;
    araddr = a; arvalid = 1'b1; i = 0;
    do begin @(negedge clk); i++; end while (!arready && i < 40);
    if (!arready) begin note_fail("ar_handshake_timeout"); arvalid = 1'b0; return; end
    @(posedge clk); #1; arvalid = 1'b0;
    idle(rdly);
    rready = 1'b1; i = 0;
    do begin @(negedge clk); i++; end while (!rvalid && i < 40);
    if (!rvalid) note_fail("r_handshake_timeout");
    @(posedge clk); #1; rready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int awd, input int wd, input int bd);
    int i;
    fork
      begin : aw_ch
        int k;
        idle(awd);
        awaddr = a; awvalid = 1'b1; k = 0;
        do begin @(negedge clk); k++; end while (!awready && k < 40);
        if (!awready) note_fail("aw_handshake_timeout");
        else begin @(posedge clk); #1; end
        awvalid = 1'b0;
      end
      begin : w_ch
        int k;
        idle(wd);
        wdata = d; wstrb = s; wvalid = 1'b1; k = 0;
        do begin @(negedge clk); k++; end while (!wready && k < 40);
        if (!wready) note_fail("w_handshake_timeout");
        else begin @(posedge clk); #1; end
        wvalid = 1'b0;
      end
    join
    idle(bd);
    bready = 1'b1; i = 0;
    do begin @(negedge clk); i++; end while (!bvalid && i < 40);
    if (!bvalid) note_fail("b_handshake_timeout");
    @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_arready"}, arready, 1'b1);
    check({tag, "_awready"}, awready, 1'b1);
    check({tag, "_wready"}, wready, 1'b1);
    check({tag, "_rvalid"}, rvalid, 1'b0);
    check({tag, "_bvalid"}, bvalid, 1'b0);
    check({tag, "_rdata"}, rdata, 32'h0);
    check({tag, "_bresp"}, bresp, 2'b00);
    check({tag, "_timer_irq"}, timer_irq, 1'b0);
    check({tag, "_soft_irq"}, soft_irq, 1'b0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r == 9) return $urandom();
    if (r == 8) return BASE + 32'h20 + 32'($urandom_range(0, 255));
    return BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [31:0] ra, wa, wd;
    logic [3:0]  ws;
    rst_n = 1'b0;
    araddr = '0; arvalid = 1'b0; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    idle(3);
    check_reset_outputs("por");
    rst_n = 1'b1;

    // free-running mtime read after ten idle cycles
    idle(10);
    rd(BASE + 32'h00, 0);

    // low-half carry into high half, then full 64-bit wrap
    wr(BASE + 32'h04, 32'h0, 4'hF, 0, 0, 0);
    wr(BASE + 32'h00, 32'hFFFF_FFFE, 4'hF, 0, 0, 0);
    idle(1);
    rd(BASE + 32'h04, 0);
    wr(BASE + 32'h04, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    wr(BASE + 32'h00, 32'hFFFF_FFFE, 4'hF, 0, 0, 0);
    rd(BASE + 32'h04, 0);
    rd(BASE + 32'h00, 0);

    // timer interrupt crossing
    wr(BASE + 32'h04, 32'h0, 4'hF, 0, 0, 0);
    wr(BASE + 32'h00, 32'h0, 4'hF, 0, 0, 0);
    wr(BASE + 32'h0C, 32'h0, 4'hF, 0, 0, 0);
    wr(BASE + 32'h08, 32'd20, 4'hF, 0, 0, 0);
    idle(25);

    // staggered msip write, zero-strobe write, unmapped write/read under backpressure
    wr(BASE + 32'h10, 32'h1, 4'b0001, 0, 3, 0);
    wr(BASE + 32'h10, 32'h0, 4'b0000, 2, 0, 1);
    wr(BASE + 32'h08, 32'h1234_5678, 4'b0110, 0, 0, 0);
    fork
      wr(BASE + 32'h14, 32'hDEAD_BEEF, 4'hF, 0, 0, 5);
      rd(BASE + 32'h18, 5);
    join
    rd(BASE + 32'h08, 0);

    for (int it = 0; it < 80; it++) begin
      ra = rand_addr();
      wa = rand_addr();
      wd = $urandom();
      ws = 4'($urandom_range(0, 15));
      if ((wa & 32'h1C) == 32'h00 && $urandom_range(0, 1) == 1) wd = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      fork
        rd(ra, $urandom_range(0, 3));
        wr(wa, wd, ws, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      join
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 4));
    end

    // reset while both channels hold an unaccepted response
    araddr = BASE + 32'h08; arvalid = 1'b1;
    awaddr = BASE + 32'h08; awvalid = 1'b1;
    wdata = $urandom(); wstrb = 4'hF; wvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    idle(2);
    check("pre_reset_rvalid", rvalid, 1'b1);
    check("pre_reset_bvalid", bvalid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid");
    idle(2);
    rst_n = 1'b1;
    rd(BASE + 32'h08, 0);
    rd(BASE + 32'h0C, 1);
    rd(BASE + 32'h10, 0);

    idle(4);
    check("rq_drained", rq.size(), 0);
    check("bq_drained", bq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
